vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_mod_counter.sv | 37 +++
 rtl/vga_sync_gen.sv | 137 +++++++++++++
 tb/tb_vga_sync_gen.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the 640x480@60 VGA sync generator.
// Default values match the standard mode; vga_sync_gen may override them per instance.
package vga_timing_pkg;

    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;
    localparam int unsigned VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Sync windows are half-open: [START, END).
    localparam int unsigned VGA_HSYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int unsigned VGA_HSYNC_END   = VGA_HSYNC_START + VGA_H_SYNC;
    localparam int unsigned VGA_VSYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int unsigned VGA_VSYNC_END   = VGA_VSYNC_START + VGA_V_SYNC;

    localparam int unsigned VGA_CLK_DIV = 4;
    localparam int unsigned DIV_W       = 4;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int unsigned SYNC_PIPE_DEPTH = 2;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-N wrap counter with enable; also exposes its next-state value so
// callers can register decodes that line up with the counter itself.
module vga_mod_counter #(
    parameter int unsigned W       = 10,
    parameter int unsigned MODULUS = 800
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         en,
    output logic [W-1:0] q,
    output logic [W-1:0] q_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    logic [W-1:0] cnt_q;

    always_comb begin
        wrap   = en && (cnt_q == LAST);
        q_next = cnt_q;
        if (en) begin
            q_next = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= q_next;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel-rate enable, scan counters, syncs, video_on, frame strobe.
// Define VGA_SYNC_PIPE_EN to delay hsync/vsync/video_on by SYNC_PIPE_DEPTH CLK cycles.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK,
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV
) (
    input  logic               CLK,
    input  logic               RESET,
    output logic               p_tick,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] unused_div_q;
    logic [DIV_W-1:0] unused_div_next;
    logic             tick_d;

    coord_t h_q, h_next;
    coord_t v_q, v_next;
    logic   h_wrap;
    logic   frame_d;

    sync_t  sync_d, sync_q, sync_out;
    logic   p_tick_q;
    logic   frame_start_q;

    // Divider wrap marks the edge on which the scan counters step.
    vga_mod_counter #(
        .W       (DIV_W),
        .MODULUS (CLK_DIV)
    ) u_div (
        .CLK    (CLK),
        .RESET  (RESET),
        .en     (1'b1),
        .q      (unused_div_q),
        .q_next (unused_div_next),
        .wrap   (tick_d)
    );

    vga_mod_counter #(
        .W       (COORD_W),
        .MODULUS (H_TOTAL)
    ) u_hcnt (
        .CLK    (CLK),
        .RESET  (RESET),
        .en     (tick_d),
        .q      (h_q),
        .q_next (h_next),
        .wrap   (h_wrap)
    );

    // Wrap of the vertical counter is exactly the (H_TOTAL-1, V_TOTAL-1) -> (0,0) step.
    vga_mod_counter #(
        .W       (COORD_W),
        .MODULUS (V_TOTAL)
    ) u_vcnt (
        .CLK    (CLK),
        .RESET  (RESET),
        .en     (h_wrap),
        .q      (v_q),
        .q_next (v_next),
        .wrap   (frame_d)
    );

    always_comb begin
        sync_d          = SYNC_IDLE;
        sync_d.hsync    = !in_window(h_next, HS_START, HS_END);
        sync_d.vsync    = !in_window(v_next, VS_START, VS_END);
        sync_d.video_on = (h_next < H_VIS) && (v_next < V_VIS);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            p_tick_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sync_q        <= SYNC_IDLE;
        end else begin
            p_tick_q      <= tick_d;
            frame_start_q <= frame_d;
            sync_q        <= sync_d;
        end
    end

`ifdef VGA_SYNC_PIPE_EN
    // Matches the font-ROM read plus registered-RGB latency downstream.
    sync_t pipe_q [SYNC_PIPE_DEPTH];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_PIPE_DEPTH; i++) begin
                pipe_q[i] <= SYNC_IDLE;
            end
        end else begin
            pipe_q[0] <= sync_q;
            for (int i = 1; i < SYNC_PIPE_DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign sync_out = pipe_q[SYNC_PIPE_DEPTH-1];
`else
    assign sync_out = sync_q;
`endif

    assign p_tick      = p_tick_q;
    assign pix_x       = h_q;
    assign pix_y       = v_q;
    assign hsync       = sync_out.hsync;
    assign vsync       = sync_out.vsync;
    assign video_on    = sync_out.video_on;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: standard mode at CLK_DIV=4 and 1, plus a
// shrunken geometry so whole frames fit in a short run.
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

`ifdef VGA_SYNC_PIPE_EN
    localparam int PIPE = SYNC_PIPE_DEPTH;
`else
    localparam int PIPE = 0;
`endif

    typedef struct {
        int    dut;
        int    tick;
        string name;
        int    x;
        int    y;
        int    hs;
        int    vs;
        int    von;
        int    fs;
    } exp_t;

    typedef struct packed {
        logic   tick;
        coord_t x;
        coord_t y;
        logic   fs;
    } smp_t;

    logic   CLK;
    logic   rst [3];
    logic   tk  [3];
    coord_t xs  [3];
    coord_t ys  [3];
    logic   hs  [3];
    logic   vs  [3];
    logic   von [3];
    logic   fs  [3];

    exp_t sq[$];
    smp_t hist [3][PIPE+1];
    int   tcnt [3];

    int n_pass  = 0;
    int n_total = 0;
    int viol_c  = 0;
    int ticks_c = 0;
    int fs_cycles = 0;
    int fs_pulses = 0;
    int fs_gap    = 0;
    logic fs_prev = 1'b0;

    vga_sync_gen u_dut_a (
        .CLK(CLK), .RESET(rst[0]), .p_tick(tk[0]), .pix_x(xs[0]), .pix_y(ys[0]),
        .hsync(hs[0]), .vsync(vs[0]), .video_on(von[0]), .frame_start(fs[0])
    );

    vga_sync_gen #(.CLK_DIV(1)) u_dut_b (
        .CLK(CLK), .RESET(rst[1]), .p_tick(tk[1]), .pix_x(xs[1]), .pix_y(ys[1]),
        .hsync(hs[1]), .vsync(vs[1]), .video_on(von[1]), .frame_start(fs[1])
    );

    // 16 x 10 geometry: hsync low on x 10..12, vsync low on y 6..7, visible x<8, y<5.
    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(2)
    ) u_dut_c (
        .CLK(CLK), .RESET(rst[2]), .p_tick(tk[2]), .pix_x(xs[2]), .pix_y(ys[2]),
        .hsync(hs[2]), .vsync(vs[2]), .video_on(von[2]), .frame_start(fs[2])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic exp_t mk(input int dut, input int tick, input string name, input int x,
                                input int y, input int h, input int v, input int o, input int f);
        exp_t e;
        e.dut = dut; e.tick = tick; e.name = name; e.x = x; e.y = y;
        e.hs = h; e.vs = v; e.von = o; e.fs = f;
        return e;
    endfunction

    task automatic check_reset(input int d, input string tag);
        check({tag, ".x"}, int'(xs[d]), 0);
        check({tag, ".y"}, int'(ys[d]), 0);
        check({tag, ".p_tick"}, int'(tk[d]), 0);
        check({tag, ".hsync"}, int'(hs[d]), 1);
        check({tag, ".vsync"}, int'(vs[d]), 1);
        check({tag, ".video_on"}, int'(von[d]), 0);
        check({tag, ".frame_start"}, int'(fs[d]), 0);
    endtask

    task automatic wait_xy(input int d, input int x, input int y, input int budget,
                           input string name);
        int n = 0;
        while (!(int'(xs[d]) == x && int'(ys[d]) == y) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (n >= budget) begin
            n_total++;
            $display("FAIL %s: timed out after %0d cycles, at (%0d,%0d), required (%0d,%0d)",
                     name, n, xs[d], ys[d], x, y);
        end
    endtask

    // Caller sits on a negedge; reset is held across exactly one active edge.
    task automatic pulse_reset(input int d, input string tag);
        #1 rst[d] = 1'b1;
        @(negedge CLK);
        check_reset(d, tag);
        #1 rst[d] = 1'b0;
    endtask

    // Monitor: a p_tick sample is a transaction; sync outputs are taken PIPE cycles later.
    initial begin
        for (int d = 0; d < 3; d++) begin
            tcnt[d] = 0;
            for (int k = 0; k <= PIPE; k++) hist[d][k] = '0;
        end
        forever begin
            @(negedge CLK);
            for (int d = 0; d < 3; d++) begin
                for (int k = PIPE; k > 0; k--) hist[d][k] = hist[d][k-1];
                hist[d][0] = '{tick: tk[d], x: xs[d], y: ys[d], fs: fs[d]};
                if (rst[d]) begin
                    tcnt[d] = 0;
                    for (int k = 0; k <= PIPE; k++) hist[d][k] = '0;
                end else if (hist[d][PIPE].tick) begin
                    smp_t h;
                    h = hist[d][PIPE];
                    tcnt[d]++;
                    if (d == 2) begin
                        if (h.y >= 5 && von[2]) viol_c++;
                        if (((h.y == 6) || (h.y == 7)) == vs[2]) viol_c++;
                        if ((h.x >= 10 && h.x <= 12) == hs[2]) viol_c++;
                    end
                    if (sq.size() > 0 && sq[0].dut == d && sq[0].tick == tcnt[d]) begin
                        exp_t e;
                        e = sq.pop_front();
                        check({e.name, ".x"}, int'(h.x), e.x);
                        check({e.name, ".y"}, int'(h.y), e.y);
                        check({e.name, ".hsync"}, int'(hs[d]), e.hs);
                        check({e.name, ".vsync"}, int'(vs[d]), e.vs);
                        check({e.name, ".video_on"}, int'(von[d]), e.von);
                        check({e.name, ".frame_start"}, int'(h.fs), e.fs);
                    end
                end
            end
        end
    end

    // Frame strobe bookkeeping for the small-geometry instance.
    initial begin
        forever begin
            @(negedge CLK);
            if (rst[2]) begin
                ticks_c = 0;
            end else begin
                if (tk[2]) ticks_c++;
                if (fs[2]) fs_cycles++;
                if (fs[2] && !fs_prev) begin
                    fs_pulses++;
                    fs_gap  = ticks_c;
                    ticks_c = 0;
                end
            end
            fs_prev = fs[2];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        int first, second, k, ones, w1, w2, fs_seen;
        rst[0] = 1'b1; rst[1] = 1'b1; rst[2] = 1'b1;
        repeat (5) @(negedge CLK);
        check_reset(0, "a.reset");
        check_reset(1, "b.reset");
        check_reset(2, "c.reset");

        // Standard mode, CLK_DIV = 4.
        sq.push_back(mk(0, 1,   "a.first_tick", 1,   0, 1, 1, 1, 0));
        sq.push_back(mk(0, 639, "a.last_vis",   639, 0, 1, 1, 1, 0));
        sq.push_back(mk(0, 640, "a.video_off",  640, 0, 1, 1, 0, 0));
        sq.push_back(mk(0, 655, "a.pre_hsync",  655, 0, 1, 1, 0, 0));
        sq.push_back(mk(0, 656, "a.hsync_fall", 656, 0, 0, 1, 0, 0));
        sq.push_back(mk(0, 751, "a.hsync_last", 751, 0, 0, 1, 0, 0));
        sq.push_back(mk(0, 752, "a.hsync_rise", 752, 0, 1, 1, 0, 0));
        sq.push_back(mk(0, 799, "a.line_end",   799, 0, 1, 1, 0, 0));
        sq.push_back(mk(0, 800, "a.line_wrap",  0,   1, 1, 1, 1, 0));
        sq.push_back(mk(0, 801, "a.line1_x1",   1,   1, 1, 1, 1, 0));
        #1 rst[0] = 1'b0;
        first = 0; second = 0;
        for (int s = 1; s <= 12; s++) begin
            @(negedge CLK);
            if (tk[0]) begin
                if (first == 0) first = s;
                else if (second == 0) second = s;
            end
        end
        check("a.first_tick_cycle", first, 4);
        check("a.tick_period", second - first, 4);

        wait_xy(0, 640, 0, 4000, "a.wait_640");
        k = 0;
        while (von[0] && k < 8) begin @(negedge CLK); k++; end
        check("a.video_on_fall_delay", k, PIPE);
        wait_xy(0, 656, 0, 200, "a.wait_656");
        k = 0;
        while (hs[0] && k < 8) begin @(negedge CLK); k++; end
        check("a.hsync_fall_delay", k, PIPE);

        wait_xy(0, 300, 1, 4000, "a.wait_300_1");
        sq.push_back(mk(0, 1, "a.recover_tick", 1, 0, 1, 1, 1, 0));
        pulse_reset(0, "a.midline_reset");
        fs_seen = 0; first = 0;
        for (int s = 1; s <= 12; s++) begin
            @(negedge CLK);
            if (fs[0]) fs_seen++;
            if (tk[0] && first == 0) first = s;
        end
        check("a.recover_first_tick", first, 4);
        check("a.recover_no_frame_start", fs_seen, 0);
        #1 rst[0] = 1'b1;

        // CLK_DIV = 1: one pixel per CLK.
        sq.push_back(mk(1, 1,   "b.first_tick", 1,   0, 1, 1, 1, 0));
        sq.push_back(mk(1, 640, "b.video_off",  640, 0, 1, 1, 0, 0));
        sq.push_back(mk(1, 656, "b.hsync_fall", 656, 0, 0, 1, 0, 0));
        sq.push_back(mk(1, 752, "b.hsync_rise", 752, 0, 1, 1, 0, 0));
        sq.push_back(mk(1, 800, "b.line_wrap",  0,   1, 1, 1, 1, 0));
        @(negedge CLK);
        #1 rst[1] = 1'b0;
        ones = 0; w1 = 0; w2 = 0;
        for (int s = 1; s <= 1600; s++) begin
            @(negedge CLK);
            if (tk[1]) ones++;
            if (s == 2) check("b.x_every_clk", int'(xs[1]), 2);
            if (xs[1] == '0) begin
                if (w1 == 0) w1 = s;
                else if (w2 == 0) w2 = s;
            end
        end
        check("b.p_tick_continuous", ones, 1600);
        check("b.first_wrap_cycle", w1, 800);
        check("b.line_period", w2 - w1, 800);
        check("b.y_after_two_lines", int'(ys[1]), 2);
        #1 rst[1] = 1'b1;

        // Small geometry, CLK_DIV = 2: 160 ticks per frame.
        sq.push_back(mk(2, 1,   "c.first_tick",   1,  0, 1, 1, 1, 0));
        sq.push_back(mk(2, 80,  "c.line5_blank",  0,  5, 1, 1, 0, 0));
        sq.push_back(mk(2, 96,  "c.vsync_fall",   0,  6, 1, 0, 0, 0));
        sq.push_back(mk(2, 122, "c.both_sync",    10, 7, 0, 0, 0, 0));
        sq.push_back(mk(2, 128, "c.vsync_rise",   0,  8, 1, 1, 0, 0));
        sq.push_back(mk(2, 159, "c.frame_end",    15, 9, 1, 1, 0, 0));
        sq.push_back(mk(2, 160, "c.frame_start",  0,  0, 1, 1, 1, 1));
        sq.push_back(mk(2, 161, "c.after_strobe", 1,  0, 1, 1, 1, 0));
        sq.push_back(mk(2, 320, "c.frame_start2", 0,  0, 1, 1, 1, 1));
        @(negedge CLK);
        #1 rst[2] = 1'b0;
        repeat (650) @(negedge CLK);
        check("c.frame_pulses", fs_pulses, 2);
        check("c.frame_start_cycles", fs_cycles, 2);
        check("c.ticks_per_frame", fs_gap, 160);
        check("c.window_violations", viol_c, 0);

        wait_xy(2, 5, 3, 400, "c.wait_5_3");
        pulse_reset(2, "c.midframe_reset");
        repeat (20) @(negedge CLK);
        check("c.no_strobe_after_reset", fs_pulses, 2);
        check("c.resume_x", int'(xs[2]), 10);
        #1 rst[2] = 1'b1;

        repeat (4) @(negedge CLK);
        check("sb_drained", sq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
